// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch (read-only) and the load/store unit.
// Optional round-robin arbitration on simultaneous requests: define ARB_RR_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_ack_o,
  output logic [DATA_W-1:0] f_rdata_o,
  input  logic              m_req_i,
  input  logic              m_we_i,
  input  logic [ADDR_W-1:0] m_addr_i,
  input  logic [DATA_W-1:0] m_wdata_i,
  output logic              m_ack_o,
  output logic [DATA_W-1:0] m_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_w_en_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              busy_o,
  output logic              grant_m_o
);

  localparam logic [2:0] CntLoad = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] m_rdata_q, m_rdata_d;

  logic any_req;
  logic pick_m;
  logic grant;
  logic capture;

  assign any_req = f_req_i | m_req_i;
  assign grant   = (state_q == StIdle) & any_req;
  assign capture = (state_q == StWait) & (cnt_q == 3'd0);

`ifdef ARB_RR_EN
  logic last_m_q, last_m_d;

  // On a tie the requester not served last wins; a lone request always wins.
  assign pick_m   = m_req_i & (~f_req_i | ~last_m_q);
  assign last_m_d = grant ? pick_m : last_m_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_m_q <= 1'b0;
    end else begin
      last_m_q <= last_m_d;
    end
  end
`else
  assign pick_m = m_req_i;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: state_d = we_q ? StAck : StWait;
      StWait:  if (cnt_q == 3'd0) state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: request latch, wait counter, read-data capture
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    f_rdata_d = f_rdata_q;
    m_rdata_d = m_rdata_q;

    if (grant) begin
      addr_d  = pick_m ? m_addr_i : f_addr_i;
      we_d    = pick_m & m_we_i;
      owner_d = pick_m;
      // Fetches never write, so the store-data latch keeps its last value.
      if (pick_m) wdata_d = m_wdata_i;
    end

    if (state_q == StIssue) begin
      cnt_d = CntLoad;
    end else if ((state_q == StWait) && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end

    if (capture) begin
      if (owner_q) begin
        m_rdata_d = ram_rdata_i;
      end else begin
        f_rdata_d = ram_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      owner_q   <= 1'b0;
      cnt_q     <= 3'd0;
      f_rdata_q <= '0;
      m_rdata_q <= '0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      f_rdata_q <= f_rdata_d;
      m_rdata_q <= m_rdata_d;
    end
  end

  // Output logic
  always_comb begin
    f_ack_o    = 1'b0;
    m_ack_o    = 1'b0;
    ram_w_en_o = 1'b0;
    busy_o     = (state_q != StIdle);
    if (state_q == StIssue) ram_w_en_o = we_q;
    if (state_q == StAck) begin
      f_ack_o = ~owner_q;
      m_ack_o = owner_q;
    end
  end

  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign grant_m_o   = owner_q;
  assign f_rdata_o   = f_rdata_q;
  assign m_rdata_o   = m_rdata_q;

endmodule
